// File: rtl/sdram_minmax_scan.sv
// Avalon-MM master: reads a block of SDRAM words and finds their min and max.
// It writes min to dst_base and max to dst_base+1, then pulses done.
module sdram_minmax_scan #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 32,
  parameter int LEN_W    = 16,
  parameter int MAX_PEND = 4,
  parameter int SIGNED   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [ADDR_W-1:0]   src_base,
  input  logic [LEN_W-1:0]    num_words,
  input  logic [ADDR_W-1:0]   dst_base,
  output logic                busy,
  output logic                done,
  output logic [DATA_W-1:0]   min_out,
  output logic [DATA_W-1:0]   max_out,
  output logic                chipselect,
  output logic                read_n,
  output logic                write_n,
  output logic [ADDR_W-1:0]   address,
  output logic [DATA_W/8-1:0] byteenable,
  output logic [DATA_W-1:0]   writedata,
  input  logic                waitrequest,
  input  logic                readdatavalid,
  input  logic [DATA_W-1:0]   readdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_WR_MIN, S_WR_MAX, S_DONE
  } state_t;

  localparam logic [DATA_W-1:0] MIN_ID = (SIGNED != 0) ? {1'b0, {(DATA_W-1){1'b1}}} : {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] MAX_ID = (SIGNED != 0) ? {1'b1, {(DATA_W-1){1'b0}}} : {DATA_W{1'b0}};
  localparam logic [3:0]        PEND_LIM = 4'(MAX_PEND);

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  src_q, dst_q;
  logic [LEN_W-1:0]   num_q, issued, received, received_nxt;
  logic [3:0]         pending;
  logic [DATA_W-1:0]  min_acc, max_acc;
  logic               can_issue, rd_accept, data_take, rd_lt, rd_gt, in_scan;

  always_comb begin
    in_scan      = (state == S_READ) || (state == S_DRAIN);
    can_issue    = (state == S_READ) && (issued < num_q) && (pending < PEND_LIM);
    rd_accept    = can_issue && !waitrequest;
    data_take    = readdatavalid && in_scan && (received < num_q);
    received_nxt = data_take ? received + LEN_W'(1) : received;
    if (SIGNED != 0) begin
      rd_lt = $signed(readdata) < $signed(min_acc);
      rd_gt = $signed(readdata) > $signed(max_acc);
    end else begin
      rd_lt = readdata < min_acc;
      rd_gt = readdata > max_acc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = (num_words == '0) ? S_WR_MIN : S_READ;
      S_READ:   if (rd_accept && (issued + LEN_W'(1) == num_q)) state_nxt = S_DRAIN;
      S_DRAIN:  if (received_nxt == num_q) state_nxt = S_WR_MIN;
      S_WR_MIN: if (!waitrequest) state_nxt = S_WR_MAX;
      S_WR_MAX: if (!waitrequest) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q    <= '0;
      dst_q    <= '0;
      num_q    <= '0;
      issued   <= '0;
      received <= '0;
      pending  <= '0;
      min_acc  <= MIN_ID;
      max_acc  <= MAX_ID;
      min_out  <= '0;
      max_out  <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        src_q    <= src_base;
        dst_q    <= dst_base;
        num_q    <= num_words;
        issued   <= '0;
        received <= '0;
        pending  <= '0;
        min_acc  <= MIN_ID;
        max_acc  <= MAX_ID;
      end
    end else begin
      if (rd_accept) issued <= issued + LEN_W'(1);
      if (data_take) begin
        received <= received_nxt;
        if (rd_lt) min_acc <= readdata;
        if (rd_gt) max_acc <= readdata;
      end
      if (rd_accept && !data_take)      pending <= pending + 4'd1;
      else if (!rd_accept && data_take) pending <= pending - 4'd1;
      // Results are loaded on entry to DONE so they are already valid while done is high.
      if (state == S_WR_MAX && !waitrequest) begin
        min_out <= min_acc;
        max_out <= max_acc;
      end
    end
  end

  always_comb begin
    read_n     = 1'b1;
    write_n    = 1'b1;
    chipselect = 1'b0;
    address    = '0;
    writedata  = '0;
    case (state)
      S_READ: begin
        chipselect = 1'b1;
        if (can_issue) begin
          read_n  = 1'b0;
          address = src_q + ADDR_W'(issued);
        end
      end
      S_DRAIN:  chipselect = 1'b1;
      S_WR_MIN: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = dst_q;
        writedata  = min_acc;
      end
      S_WR_MAX: begin
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = dst_q + ADDR_W'(1);
        writedata  = max_acc;
      end
      default: ;
    endcase
    byteenable = chipselect ? '1 : '0;
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
  end

endmodule
